// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between ALU, load and MDU results (WB_PERF_EN adds perf counters).
// Latency: combinational grant, registered write on rf_* one cycle after the grant.
// Backpressure: ld/mdu wait on ready; the ALU is frozen via alu_stall_o once a slow request starves.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_stall_o,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_rd_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  input  logic              mdu_valid_i,
  input  logic [ADDR_W-1:0] mdu_rd_i,
  input  logic [DATA_W-1:0] mdu_data_i,
  output logic              mdu_ready_o,
`ifdef WB_PERF_EN
  output logic [31:0]       conflict_cnt_o,
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        ptr_mdu_q, ptr_mdu_d;
  logic        gnt_alu, gnt_ld, gnt_mdu, gnt_any, gnt_slow;
  logic        slow_pend, slow_left;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      starve_q  <= '0;
      ptr_mdu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      ptr_mdu_q <= ptr_mdu_d;
    end
  end

  assign slow_pend = ld_valid_i | mdu_valid_i;
  assign gnt_slow  = gnt_ld | gnt_mdu;
  assign gnt_any   = gnt_alu | gnt_slow;
  // a slow request still waiting after this cycle's grant keeps DRAIN alive
  assign slow_left = (ld_valid_i & ~gnt_ld) | (mdu_valid_i & ~gnt_mdu);

  always_comb begin
    state_d   = state_q;
    ptr_mdu_d = ptr_mdu_q;
    starve_d  = starve_q;
    if (gnt_slow) ptr_mdu_d = gnt_ld;
    if (gnt_slow || !slow_pend) starve_d = '0;
    else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
    case (state_q)
      NORMAL: if (starve_d >= LIMIT) state_d = DRAIN;
      DRAIN: begin
        if (!slow_left) begin
          state_d  = NORMAL;
          starve_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    gnt_alu = 1'b0;
    gnt_ld  = 1'b0;
    gnt_mdu = 1'b0;
    if (state_q == NORMAL && alu_valid_i) begin
      gnt_alu = 1'b1;
    end else if (ld_valid_i && mdu_valid_i) begin
      gnt_ld  = ~ptr_mdu_q;
      gnt_mdu = ptr_mdu_q;
    end else begin
      gnt_ld  = ld_valid_i;
      gnt_mdu = mdu_valid_i;
    end
  end

  assign alu_stall_o = (state_q == DRAIN);
  assign ld_ready_o  = gnt_ld;
  assign mdu_ready_o = gnt_mdu;

  always_comb begin
    wr_rd   = alu_rd_i;
    wr_data = alu_data_i;
    if (gnt_ld) begin
      wr_rd   = ld_rd_i;
      wr_data = ld_data_i;
    end else if (gnt_mdu) begin
      wr_rd   = mdu_rd_i;
      wr_data = mdu_data_i;
    end
  end

  // x0 grants consume the slot but never raise the write enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= gnt_any && (wr_rd != '0);
      if (gnt_any) begin
        rf_waddr_o <= wr_rd;
        rf_wdata_o <= wr_data;
      end
    end
  end

`ifdef WB_PERF_EN
  logic [1:0] n_req;
  assign n_req = {1'b0, alu_valid_i} + {1'b0, ld_valid_i} + {1'b0, mdu_valid_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (n_req >= 2'd2) conflict_cnt_o <= conflict_cnt_o + 32'd1;
      if (alu_stall_o)   stall_cnt_o    <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_wb_port_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;
  localparam int W_NONE = 0, W_ALU = 1, W_LD = 2, W_MDU = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid_i = 1'b0, ld_valid_i = 1'b0, mdu_valid_i = 1'b0;
  logic [AW-1:0] alu_rd_i = '0, ld_rd_i = '0, mdu_rd_i = '0;
  logic [DW-1:0] alu_data_i = '0, ld_data_i = '0, mdu_data_i = '0;
  logic          alu_stall_o, ld_ready_o, mdu_ready_o, rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
`ifdef WB_PERF_EN
  logic [31:0]   conflict_cnt_o, stall_cnt_o;
  logic [31:0]   m_conf = '0, m_stall = '0;
`endif

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_stall_o(alu_stall_o),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i), .mdu_ready_o(mdu_ready_o),
`ifdef WB_PERF_EN
    .conflict_cnt_o(conflict_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: which source owns the port this cycle and how long a slow request has waited.
  bit            m_drain = 0;
  bit            m_pref_mdu = 0;
  int            m_blk = 0;
  int            m_who, m_first, m_second;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_dat;

  function automatic bit m_req(input int w);
    return (w == W_LD) ? ld_valid_i : mdu_valid_i;
  endfunction

  task automatic mdl_reset();
    sbq.delete();
    m_drain = 0;
    m_pref_mdu = 0;
    m_blk = 0;
`ifdef WB_PERF_EN
    m_conf = '0;
    m_stall = '0;
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      m_who = W_NONE;
      if (!m_drain && alu_valid_i) begin
        m_who = W_ALU;
      end else begin
        m_first  = m_pref_mdu ? W_MDU : W_LD;
        m_second = m_pref_mdu ? W_LD : W_MDU;
        if (m_req(m_first)) m_who = m_first;
        else if (m_req(m_second)) m_who = m_second;
      end
      chk("ld_ready", ld_ready_o, m_who == W_LD);
      chk("mdu_ready", mdu_ready_o, m_who == W_MDU);
      chk("alu_stall", alu_stall_o, m_drain);
`ifdef WB_PERF_EN
      chk("conflict_cnt", conflict_cnt_o, m_conf);
      chk("stall_cnt", stall_cnt_o, m_stall);
      if (int'(alu_valid_i) + int'(ld_valid_i) + int'(mdu_valid_i) >= 2) m_conf++;
      if (m_drain) m_stall++;
`endif
      if (m_who != W_NONE) begin
        m_rd  = (m_who == W_ALU) ? alu_rd_i : (m_who == W_LD) ? ld_rd_i : mdu_rd_i;
        m_dat = (m_who == W_ALU) ? alu_data_i : (m_who == W_LD) ? ld_data_i : mdu_data_i;
        if (m_rd != '0) sbq.push_back('{cyc + 1, m_rd, m_dat});
      end
      if ((ld_valid_i || mdu_valid_i) && !(m_who == W_LD || m_who == W_MDU))
        m_blk = (m_blk < 15) ? m_blk + 1 : 15;
      else
        m_blk = 0;
      if (m_who == W_LD) m_pref_mdu = 1;
      else if (m_who == W_MDU) m_pref_mdu = 0;
      if (m_drain) begin
        if (!((ld_valid_i && m_who != W_LD) || (mdu_valid_i && m_who != W_MDU))) begin
          m_drain = 0;
          m_blk = 0;
        end
      end else if (m_blk >= LIM) begin
        m_drain = 1;
      end
    end
  end

  // Monitor: every write the DUT presents must match the oldest expected write and its cycle.
  wr_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].c < cyc) begin
        mon_e = sbq.pop_front();
        chk("wr_missed_cycle", cyc, mon_e.c);
      end
      if (rf_we_o) begin
        if (sbq.size() == 0) begin
          chk("wr_spurious", rf_we_o, 1'b0);
        end else begin
          mon_e = sbq.pop_front();
          chk("wr_cycle", cyc, mon_e.c);
          chk("wr_addr", rf_waddr_o, mon_e.a);
          chk("wr_data", rf_wdata_o, mon_e.d);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    ld_valid_i  = 1'b0;
    mdu_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", rf_we_o, 1'b0);
    chk("rst_waddr", rf_waddr_o, '0);
    chk("rst_wdata", rf_wdata_o, '0);
    chk("rst_stall", alu_stall_o, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int n, input int pa, input int pl, input int pm);
    logic acc_l, acc_m, stl;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc_l = ld_valid_i & ld_ready_o;
      acc_m = mdu_valid_i & mdu_ready_o;
      stl   = alu_stall_o;
      nxt();
      if (!stl) begin
        alu_valid_i = ($urandom_range(99) < pa);
        alu_rd_i    = AW'($urandom);
        alu_data_i  = $urandom;
      end
      if (!ld_valid_i || acc_l) begin
        ld_valid_i = ($urandom_range(99) < pl);
        ld_rd_i    = AW'($urandom);
        ld_data_i  = $urandom;
      end
      if (!mdu_valid_i || acc_m) begin
        mdu_valid_i = ($urandom_range(99) < pm);
        mdu_rd_i    = AW'($urandom);
        mdu_data_i  = $urandom;
      end
    end
  endtask

  initial begin
    // ALU only
    do_reset();
    alu_valid_i = 1'b1; alu_rd_i = 5; alu_data_i = 32'h1234;
    nxt(); alu_valid_i = 1'b0;
    mid();
    chk("alu_we_c1", rf_we_o, 1'b1);
    chk("alu_addr_c1", rf_waddr_o, 5);
    chk("alu_data_c1", rf_wdata_o, 32'h1234);
    nxt(); mid();
    chk("alu_we_c2", rf_we_o, 1'b0);
    chk("alu_hold_addr_c2", rf_waddr_o, 5);

    // LD and MDU together
    do_reset();
    ld_valid_i = 1'b1; ld_rd_i = 3; ld_data_i = 32'h33;
    mdu_valid_i = 1'b1; mdu_rd_i = 7; mdu_data_i = 32'h77;
    mid();
    chk("lm_ldrdy_c0", ld_ready_o, 1'b1);
    chk("lm_mdurdy_c0", mdu_ready_o, 1'b0);
    nxt(); ld_valid_i = 1'b0;
    mid();
    chk("lm_mdurdy_c1", mdu_ready_o, 1'b1);
    chk("lm_we_c1", rf_we_o, 1'b1);
    chk("lm_addr_c1", rf_waddr_o, 3);
    nxt(); mdu_valid_i = 1'b0;
    mid();
    chk("lm_we_c2", rf_we_o, 1'b1);
    chk("lm_addr_c2", rf_waddr_o, 7);
    chk("lm_data_c2", rf_wdata_o, 32'h77);

    // starvation of a load behind a continuous ALU stream
    do_reset();
    alu_valid_i = 1'b1; alu_rd_i = 9; alu_data_i = 32'hA5A5_0009;
    ld_valid_i = 1'b1; ld_rd_i = 4; ld_data_i = 32'h4444;
    for (int k = 0; k < 7; k++) begin
      mid();
      chk($sformatf("st_stall_c%0d", k), alu_stall_o, k == 4);
      chk($sformatf("st_ldrdy_c%0d", k), ld_ready_o, k == 4);
      if (k == 5) chk("st_ld_wr_c5", rf_waddr_o, 4);
      if (k == 6) begin
        chk("st_alu_we_c6", rf_we_o, 1'b1);
        chk("st_alu_wr_c6", rf_waddr_o, 9);
      end
      nxt();
      if (k == 4) ld_valid_i = 1'b0;
    end
    alu_valid_i = 1'b0;

    // write to x0
    do_reset();
    mdu_valid_i = 1'b1; mdu_rd_i = 0; mdu_data_i = 32'hFFFF_FFFF;
    mid();
    chk("x0_rdy", mdu_ready_o, 1'b1);
    nxt(); mdu_valid_i = 1'b0;
    mid();
    chk("x0_we", rf_we_o, 1'b0);

    // reset while draining
    do_reset();
    alu_valid_i = 1'b1; alu_rd_i = 9; alu_data_i = 32'h9999;
    ld_valid_i = 1'b1; ld_rd_i = 3; ld_data_i = 32'h3333;
    mdu_valid_i = 1'b1; mdu_rd_i = 7; mdu_data_i = 32'h7777;
    repeat (4) nxt();
    chk("rd_pre_stall", alu_stall_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rd_stall_async", alu_stall_o, 1'b0);
    chk("rd_we_async", rf_we_o, 1'b0);
    mdl_reset();
    alu_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mid();
    chk("rd_ld_first", ld_ready_o, 1'b1);
    chk("rd_mdu_wait", mdu_ready_o, 1'b0);
    nxt(); ld_valid_i = 1'b0;
    mid();
    chk("rd_mdu_next", mdu_ready_o, 1'b1);
    nxt(); mdu_valid_i = 1'b0;

    // random traffic at several load mixes
    do_reset();
    run_random(2000, 60, 40, 30);
    run_random(1000, 90, 50, 50);
    run_random(500, 20, 70, 70);
    idle_inputs();
    repeat (3) nxt();
    mid();
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
